// File: rtl/sobel_mac_sequencer.sv
// sobel_mac_sequencer
//   Drives one SB_MAC16 (8x8 mode, bottom multiplier + accumulator) to compute
//   the Sobel gradients Gx and Gy of a 3x3 window. Each kernel is issued as six
//   nonzero taps. The sequence is: clear, six X taps, capture gx and clear,
//   six Y taps, then capture gy and present the result.
//
//   Configuration macro: SOBEL_MAC_SAT_EN
//     defined   : mag_o = min(|gx|+|gy|, 255)
//     undefined : mag_o = (|gx|+|gy|) >> (GRAD_W-8)
//
// Ports
//   clk_i, rst_ni                clock, synchronous active-low reset
//   win_i, in_valid_i, in_ready_o 3x3 window p0..p8 (p0 in the LSBs), handshake
//   gx_o, gy_o, mag_o            signed gradients and 8-bit magnitude
//   out_valid_o, out_ready_i     result handshake; result held until taken
//   mac_*_o                      SB_MAC16 control and operands (CE, A, B, D,
//                                OLOADBOT, ADDSUBBOT, ORSTBOT)
//   mac_o_i                      SB_MAC16 O; [15:0] is the accumulator
module sobel_mac_sequencer #(
  parameter int PIX_W  = 8,
  parameter int GRAD_W = PIX_W + 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [9*PIX_W-1:0]       win_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  output logic signed [GRAD_W-1:0] gx_o,
  output logic signed [GRAD_W-1:0] gy_o,
  output logic [7:0]               mag_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic                     mac_ce_o,
  output logic [15:0]              mac_a_o,
  output logic [15:0]              mac_b_o,
  output logic [15:0]              mac_d_o,
  output logic                     mac_oloadbot_o,
  output logic                     mac_addsubbot_o,
  output logic                     mac_orstbot_o,
  input  logic [31:0]              mac_o_i
);

  localparam int MAG_SHIFT = (GRAD_W > 8) ? (GRAD_W - 8) : 0;

  typedef enum logic [2:0] {
    S_IDLE, S_LOADX, S_TAPX, S_CAPX, S_TAPY, S_CAPY, S_OUT
  } state_t;

  typedef struct packed {
    logic [3:0] pix;   // pixel index 0..8
    logic       neg;   // subtract product
    logic       dbl;   // |coef| = 2
  } tap_t;

  state_t                     state;
  logic [2:0]                 tap;
  logic [9*PIX_W-1:0]         win_p0;
  logic signed [GRAD_W-1:0]   gx_p1;
  logic signed [GRAD_W-1:0]   gy_p1;
  logic [7:0]                 mag_p1;
  logic                       vld_p1;

  logic [PIX_W-1:0]           pix [9];
  tap_t                       cur;
  logic signed [GRAD_W-1:0]   acc_grad;
  logic                       unused_mac_bits;

  // Nonzero Sobel taps in issue order. Gx columns: -1 0 +1 / -2 0 +2 / -1 0 +1;
  // Gy rows: -1 -2 -1 / 0 0 0 / +1 +2 +1.
  function automatic tap_t tap_lookup(input logic is_y, input logic [2:0] n);
    tap_t t;
    t = '0;
    if (!is_y) begin
      case (n)
        3'd0: begin t.pix = 4'd0; t.neg = 1'b1; t.dbl = 1'b0; end
        3'd1: begin t.pix = 4'd2; t.neg = 1'b0; t.dbl = 1'b0; end
        3'd2: begin t.pix = 4'd3; t.neg = 1'b1; t.dbl = 1'b1; end
        3'd3: begin t.pix = 4'd5; t.neg = 1'b0; t.dbl = 1'b1; end
        3'd4: begin t.pix = 4'd6; t.neg = 1'b1; t.dbl = 1'b0; end
        3'd5: begin t.pix = 4'd8; t.neg = 1'b0; t.dbl = 1'b0; end
        default: t = '0;
      endcase
    end else begin
      case (n)
        3'd0: begin t.pix = 4'd0; t.neg = 1'b1; t.dbl = 1'b0; end
        3'd1: begin t.pix = 4'd1; t.neg = 1'b1; t.dbl = 1'b1; end
        3'd2: begin t.pix = 4'd2; t.neg = 1'b1; t.dbl = 1'b0; end
        3'd3: begin t.pix = 4'd6; t.neg = 1'b0; t.dbl = 1'b0; end
        3'd4: begin t.pix = 4'd7; t.neg = 1'b0; t.dbl = 1'b1; end
        3'd5: begin t.pix = 4'd8; t.neg = 1'b0; t.dbl = 1'b0; end
        default: t = '0;
      endcase
    end
    return t;
  endfunction

  function automatic logic [15:0] abs_grad(input logic signed [GRAD_W-1:0] v);
    logic signed [15:0] ext;
    ext = 16'(v);
    return (ext < 0) ? 16'(-ext) : 16'(ext);
  endfunction

  // Magnitude reduction to 8 bits: clamp or drop LSBs depending on build.
  function automatic logic [7:0] mag_reduce(input logic signed [GRAD_W-1:0] gx,
                                            input logic signed [GRAD_W-1:0] gy);
    logic [15:0] sum;
    sum = abs_grad(gx) + abs_grad(gy);
`ifdef SOBEL_MAC_SAT_EN
    return (sum > 16'd255) ? 8'hFF : sum[7:0];
`else
    return 8'(sum >> MAG_SHIFT);
`endif
  endfunction

  for (genvar i = 0; i < 9; i++) begin : g_pix
    assign pix[i] = win_p0[i*PIX_W +: PIX_W];
  end

  assign acc_grad        = $signed(mac_o_i[GRAD_W-1:0]);
  assign unused_mac_bits = ^mac_o_i[31:GRAD_W];

  assign mac_d_o       = 16'h0000;
  assign mac_orstbot_o = ~rst_ni;

  assign gx_o        = gx_p1;
  assign gy_o        = gy_p1;
  assign mag_o       = mag_p1;
  assign out_valid_o = vld_p1;

  // MAC controls are decoded from the registered state; reset forces them
  // inactive even before the first reset edge has been seen.
  always_comb begin
    cur             = tap_lookup(state == S_TAPY, tap);
    in_ready_o      = 1'b0;
    mac_ce_o        = 1'b0;
    mac_oloadbot_o  = 1'b0;
    mac_addsubbot_o = 1'b0;
    mac_a_o         = 16'h0000;
    mac_b_o         = 16'h0000;
    if (rst_ni) begin
      in_ready_o     = (state == S_IDLE);
      mac_ce_o       = (state == S_LOADX) || (state == S_TAPX) || (state == S_CAPX) ||
                       (state == S_TAPY)  || (state == S_CAPY);
      mac_oloadbot_o = (state == S_LOADX) || (state == S_CAPX);
      if ((state == S_TAPX) || (state == S_TAPY)) begin
        mac_a_o         = {{(16-PIX_W){1'b0}}, pix[cur.pix]};
        mac_b_o         = cur.dbl ? 16'd2 : 16'd1;
        mac_addsubbot_o = cur.neg;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state  <= S_IDLE;
      tap    <= 3'd0;
      win_p0 <= '0;
      gx_p1  <= '0;
      gy_p1  <= '0;
      mag_p1 <= 8'd0;
      vld_p1 <= 1'b0;
    end else begin
      case (state)
        // window latch
        S_IDLE: begin
          if (in_valid_i) begin
            win_p0 <= win_i;
            state  <= S_LOADX;
          end
        end
        S_LOADX: begin
          tap   <= 3'd0;
          state <= S_TAPX;
        end
        S_TAPX: begin
          if (tap == 3'd5) begin
            tap   <= 3'd0;
            state <= S_CAPX;
          end else begin
            tap <= tap + 3'd1;
          end
        end
        // gx capture; the accumulator is reloaded with 0 on this same edge
        S_CAPX: begin
          gx_p1 <= acc_grad;
          state <= S_TAPY;
        end
        S_TAPY: begin
          if (tap == 3'd5) begin
            tap   <= 3'd0;
            state <= S_CAPY;
          end else begin
            tap <= tap + 3'd1;
          end
        end
        // gy capture and magnitude; result registers
        S_CAPY: begin
          gy_p1  <= acc_grad;
          mag_p1 <= mag_reduce(gx_p1, acc_grad);
          vld_p1 <= 1'b1;
          state  <= S_OUT;
        end
        S_OUT: begin
          if (out_ready_i) begin
            vld_p1 <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_mac_sequencer.sv
module tb_sobel_mac_sequencer;

  localparam int PIX_W  = 8;
  localparam int GRAD_W = PIX_W + 3;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [9*PIX_W-1:0]       win;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [GRAD_W-1:0] gx;
  logic signed [GRAD_W-1:0] gy;
  logic [7:0]               mag;
  logic                     out_valid;
  logic                     out_ready;
  logic                     mac_ce;
  logic [15:0]              mac_a;
  logic [15:0]              mac_b;
  logic [15:0]              mac_d;
  logic                     mac_oload;
  logic                     mac_addsub;
  logic                     mac_orst;
  logic [31:0]              mac_o;
  logic [15:0]              rs;

  always #5 clk = ~clk;

  sobel_mac_sequencer #(.PIX_W(PIX_W), .GRAD_W(GRAD_W)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .win_i           (win),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready),
    .gx_o            (gx),
    .gy_o            (gy),
    .mag_o           (mag),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .mac_ce_o        (mac_ce),
    .mac_a_o         (mac_a),
    .mac_b_o         (mac_b),
    .mac_d_o         (mac_d),
    .mac_oloadbot_o  (mac_oload),
    .mac_addsubbot_o (mac_addsub),
    .mac_orstbot_o   (mac_orst),
    .mac_o_i         (mac_o)
  );

  // SB_MAC16 bottom half, 8x8 unsigned, unregistered inputs, accumulator output
  always @(posedge clk or posedge mac_orst) begin
    if (mac_orst)
      rs <= 16'h0000;
    else if (mac_ce) begin
      if (mac_oload)
        rs <= mac_d;
      else if (mac_addsub)
        rs <= rs - 16'(mac_a[7:0] * mac_b[7:0]);
      else
        rs <= rs + 16'(mac_a[7:0] * mac_b[7:0]);
    end
  end
  assign mac_o = {16'h0000, rs};

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    int gx;
    int gy;
    int mag;
  } exp_t;

  exp_t q[$];

  function automatic exp_t model(input logic [9*PIX_W-1:0] w);
    int   p[9];
    int   s;
    exp_t e;
    for (int i = 0; i < 9; i++) p[i] = int'(w[i*PIX_W +: PIX_W]);
    e.gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
    e.gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
    s = (e.gx < 0 ? -e.gx : e.gx) + (e.gy < 0 ? -e.gy : e.gy);
`ifdef SOBEL_MAC_SAT_EN
    e.mag = (s > 255) ? 255 : s;
`else
    e.mag = s / 8;
`endif
    return e;
  endfunction

  function automatic logic [9*PIX_W-1:0] setpx(input logic [9*PIX_W-1:0] w,
                                               input int i, input int v);
    w[i*PIX_W +: PIX_W] = PIX_W'(v);
    return w;
  endfunction

  int   cyc = 0;
  int   accept_edge = 0;
  logic lat_pending = 1'b0;
  logic ov_prev = 1'b0;
  logic saw_sub10 = 1'b0;
  logic saw_add40_wrong = 1'b0;

  always @(posedge clk) cyc++;

  // Scoreboard monitor: sample between active edges.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (in_valid && in_ready) begin
        q.push_back(model(win));
        accept_edge = cyc + 1;
        lat_pending = 1'b1;
      end
      if (out_valid && !ov_prev && lat_pending) begin
        check("latency", cyc - accept_edge, 15);
        lat_pending = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("sb_unexpected_output", 1, 0);
        end else begin
          e = q.pop_front();
          check("gx", gx, e.gx);
          check("gy", gy, e.gy);
          check("mag", mag, e.mag);
        end
      end
      if (mac_ce && mac_addsub && mac_a == 16'd10) saw_sub10 = 1'b1;
      if (mac_ce && mac_addsub && mac_a == 16'd40) saw_add40_wrong = 1'b1;
    end
    ov_prev = out_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [9*PIX_W-1:0] w);
    int n;
    n = 0;
    in_valid = 1'b1;
    win = w;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) check("accept_timeout", 1, 0);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) check("drain_timeout", 1, 0);
  endtask

  initial begin
    logic [9*PIX_W-1:0]       w;
    logic signed [GRAD_W-1:0] hgx;
    logic signed [GRAD_W-1:0] hgy;
    logic [7:0]               hmag;
    int                       n;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    win       = '0;
    out_ready = 1'b1;
    repeat (3) step();

    // Reset state
    check("rst_in_ready", in_ready, 0);
    check("rst_mac_ce", mac_ce, 0);
    check("rst_orstbot", mac_orst, 1);
    check("rst_oload", mac_oload, 0);
    check("rst_addsub", mac_addsub, 0);
    check("rst_mac_a", mac_a, 0);
    check("rst_mac_b", mac_b, 0);
    check("rst_mac_d", mac_d, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_gx", gx, 0);
    check("rst_gy", gy, 0);
    check("rst_mag", mag, 0);
    rst_n = 1'b1;
    #1;
    check("release_in_ready", in_ready, 1);
    check("release_orstbot", mac_orst, 0);

    // All-zero window
    send('0);
    drain();

    // Right column bright: gx=+1020
    w = '0;
    w = setpx(w, 2, 255); w = setpx(w, 5, 255); w = setpx(w, 8, 255);
    send(w);
    drain();

    // Top row bright: gy=-1020
    w = '0;
    w = setpx(w, 0, 255); w = setpx(w, 1, 255); w = setpx(w, 2, 255);
    send(w);
    drain();

    // p3=10, p5=40: subtract only on the p3 tap
    saw_sub10 = 1'b0;
    saw_add40_wrong = 1'b0;
    w = '0;
    w = setpx(w, 3, 10); w = setpx(w, 5, 40);
    send(w);
    drain();
    check("addsub_on_p3", saw_sub10, 1);
    check("no_sub_on_p5", saw_add40_wrong, 0);

    // Downstream stall for 5 cycles in OUT
    out_ready = 1'b0;
    w = '0;
    w = setpx(w, 0, 17); w = setpx(w, 4, 200); w = setpx(w, 7, 99); w = setpx(w, 8, 3);
    send(w);
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) check("out_valid_timeout", 1, 0);
    hgx  = gx;
    hgy  = gy;
    hmag = mag;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_gx", gx, hgx);
      check("stall_gy", gy, hgy);
      check("stall_mag", mag, hmag);
      check("stall_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_mac_ce", mac_ce, 0);
    end
    out_ready = 1'b1;

    // Back-to-back windows
    w = '0;
    w = setpx(w, 6, 255); w = setpx(w, 7, 128); w = setpx(w, 1, 5);
    send(w);
    w = '0;
    w = setpx(w, 0, 1); w = setpx(w, 3, 2); w = setpx(w, 8, 250);
    send(w);
    drain();

    // Reset pulse during TAPY tap 2
    w = '0;
    w = setpx(w, 2, 77); w = setpx(w, 5, 9);
    send(w);
    repeat (10) step();
    check("tapy2_mac_a", mac_a, 77);
    check("tapy2_mac_b", mac_b, 1);
    check("tapy2_addsub", mac_addsub, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_mac_ce", mac_ce, 0);
    check("midrst_orstbot", mac_orst, 1);
    check("midrst_mac_a", mac_a, 0);
    check("midrst_mac_b", mac_b, 0);
    check("midrst_addsub", mac_addsub, 0);
    check("midrst_rs", rs, 0);
    step();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_gx", gx, 0);
    check("midrst_gy", gy, 0);
    check("midrst_mag", mag, 0);
    q.delete();
    lat_pending = 1'b0;
    rst_n = 1'b1;
    #1;
    check("postrst_in_ready", in_ready, 1);
    w = '0;
    w = setpx(w, 2, 255); w = setpx(w, 5, 255); w = setpx(w, 8, 255);
    send(w);
    drain();

    // A few random windows
    for (int k = 0; k < 4; k++) begin
      w = '0;
      for (int i = 0; i < 9; i++) w = setpx(w, i, int'($urandom_range(0, 255)));
      send(w);
    end
    drain();
    check("sb_empty_at_end", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
